bcd_ex3_counter: RTL

BCD_EX3_COUNTER -- requirements
Module: bcd_ex3_counter

---
 rtl/bcd_ex3_pkg.sv | 13 +
 rtl/bcd_ex3_digit.sv | 39 +++
 rtl/bcd_ex3_counter.sv | 52 +++++
 3 files changed

// File: rtl/bcd_ex3_pkg.sv
// Shared constants and helpers for the BCD up/down counter with excess-3 decode.
// Imported by the digit slice and by the counter top.
package bcd_ex3_pkg;

  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] BCD_MAX    = 4'd9;
  localparam logic [DIGIT_W-1:0] EX3_OFFSET = 4'd3;

  function automatic logic is_bcd(input logic [DIGIT_W-1:0] nib);
    return nib <= BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_ex3_digit.sv
// One BCD digit register with ripple carry/borrow, sanitising parallel load,
// and a combinational excess-3 view of the stored digit.
module bcd_ex3_digit
  import bcd_ex3_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [DIGIT_W-1:0] load_nib,
  input  logic               up_dn,
  input  logic               step_in,
  output logic               step_out,
  output logic               nib_err,
  output logic [DIGIT_W-1:0] q,
  output logic [DIGIT_W-1:0] ex3
);

  logic at_terminal;

  // Terminal digit depends on direction: 9 rolls over going up, 0 going down.
  always_comb begin
    at_terminal = up_dn ? (q == BCD_MAX) : (q == '0);
    step_out    = step_in & at_terminal;
    nib_err     = load & ~is_bcd(load_nib);
    ex3         = q + EX3_OFFSET;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= is_bcd(load_nib) ? load_nib : '0;
    end else if (step_in) begin
      if (up_dn) q <= at_terminal ? '0 : q + 4'd1;
      else       q <= at_terminal ? BCD_MAX : q - 4'd1;
    end
  end

endmodule

// File: rtl/bcd_ex3_counter.sv
// Multi-digit BCD up/down counter with parallel load and excess-3 output.
// The top only chains digit slices and registers the wrap / load_err pulses.
module bcd_ex3_counter
  import bcd_ex3_pkg::*;
#(
  parameter int DIGITS = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      up_dn,
  input  logic                      load,
  input  logic [DIGIT_W*DIGITS-1:0] load_val,
  output logic [DIGIT_W*DIGITS-1:0] q_bcd,
  output logic [DIGIT_W*DIGITS-1:0] q_ex3,
  output logic                      wrap,
  output logic                      load_err
);

  logic [DIGITS:0]   carry;
  logic [DIGITS-1:0] nib_err;

  // Load wins over count, so the chain is only fed when no load is pending;
  // this also keeps a loaded terminal value from flagging a wrap.
  assign carry[0] = en & ~load;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_ex3_digit u_digit (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load),
      .load_nib (load_val[DIGIT_W*i +: DIGIT_W]),
      .up_dn    (up_dn),
      .step_in  (carry[i]),
      .step_out (carry[i+1]),
      .nib_err  (nib_err[i]),
      .q        (q_bcd[DIGIT_W*i +: DIGIT_W]),
      .ex3      (q_ex3[DIGIT_W*i +: DIGIT_W])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      wrap     <= carry[DIGITS];
      load_err <= |nib_err;
    end
  end

endmodule
